// File: rtl/adpll_loop_ctrl.sv
// ADPLL loop controller: two-stage PI loop filter driving a clipped DCO word,
// with programmable gains/centre and an error-magnitude lock detector.
module adpll_loop_ctrl #(
  parameter int unsigned W       = 8,
  parameter int unsigned ACC_EXT = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         pgm,
  input  logic [2:0]   param_sel,
  input  logic [W-1:0] pgm_value,
  input  logic         err_valid,
  input  logic [W-1:0] err_mag,
  input  logic         err_sign,
  input  logic [1:0]   out_sel,
  output logic [W-1:0] dco_word,
  output logic         out_valid,
  output logic [W-1:0] dout,
  output logic         sign,
  output logic         locked,
  output logic         integ_sat
);

  localparam int unsigned IW = W + 1 + ACC_EXT;

  localparam logic [W-1:0]         CenterDef = {1'b1, {(W-1){1'b0}}};
  localparam logic [W-1:0]         ThrDef    = W'(2);
  localparam logic [W-1:0]         LcntDef   = W'(16);
  localparam logic [2:0]           KpDef     = 3'd2;
  localparam logic [2:0]           KiDef     = 3'd5;
  localparam logic signed [IW-1:0] IntegMax  = {1'b0, {(IW-1){1'b1}}};
  localparam logic signed [IW-1:0] IntegMin  = {1'b1, {(IW-1){1'b0}}};

  typedef enum logic [1:0] {
    StUnlocked = 2'd0,
    StAcquire  = 2'd1,
    StLocked   = 2'd2
  } state_e;

  logic [2:0]           kp_q, kp_d, ki_q, ki_d;
  logic [W-1:0]         center_q, center_d, thr_q, thr_d, lcnt_q, lcnt_d;
  logic signed [W:0]    prop_q, prop_d, f_q, f_d;
  logic signed [IW-1:0] integ_q, integ_d;
  logic                 s1_valid_q, s1_valid_d, out_valid_q, out_valid_d;
  logic [W-1:0]         dco_q, dco_d, dout_q, dout_d, cnt_q, cnt_d;
  logic                 sign_q, sign_d;
  state_e               state_q, state_d;

  // Stage 1 datapath: signed error, proportional term, saturating integrator.
  logic signed [W:0]    e, e_p, e_i;
  logic signed [IW:0]   isum;
  logic signed [IW-1:0] isat;

  always_comb begin
    e = $signed({1'b0, err_mag});
    if (err_sign) e = -e;
    e_p  = e >>> kp_q;
    e_i  = e >>> ki_q;
    isum = $signed({integ_q[IW-1], integ_q}) + $signed({{(IW-W){e_i[W]}}, e_i});
    if (isum[IW] != isum[IW-1]) isat = isum[IW] ? IntegMin : IntegMax;
    else                        isat = isum[IW-1:0];
  end

  // Stage 2 datapath: filter sum saturated to W+1 bits, then centred and clipped.
  logic signed [IW:0]  fsum;
  logic signed [W:0]   fsat;
  logic signed [W+1:0] dsum;
  logic [W-1:0]        dclip;
  logic                ffits;

  always_comb begin
    fsum  = $signed({{(IW-W){prop_q[W]}}, prop_q}) + $signed({integ_q[IW-1], integ_q});
    ffits = (&fsum[IW:W]) | ~(|fsum[IW:W]);
    if (ffits)         fsat = fsum[W:0];
    else if (fsum[IW]) fsat = {1'b1, {W{1'b0}}};
    else               fsat = {1'b0, {W{1'b1}}};
    dsum = $signed({2'b00, center_q}) + $signed({fsat[W], fsat});
    if (dsum[W+1])   dclip = '0;
    else if (dsum[W]) dclip = '1;
    else             dclip = dsum[W-1:0];
  end

  // Parameter registers.
  always_comb begin
    kp_d     = kp_q;
    ki_d     = ki_q;
    center_d = center_q;
    thr_d    = thr_q;
    lcnt_d   = lcnt_q;
    if (clr) begin
      kp_d     = KpDef;
      ki_d     = KiDef;
      center_d = CenterDef;
      thr_d    = ThrDef;
      lcnt_d   = LcntDef;
    end else if (pgm) begin
      case (param_sel)
        3'd0:    kp_d     = pgm_value[2:0];
        3'd1:    ki_d     = pgm_value[2:0];
        3'd2:    center_d = pgm_value;
        3'd3:    thr_d    = pgm_value;
        3'd4:    lcnt_d   = pgm_value;
        default: ;
      endcase
    end
  end

  // Filter pipeline.
  always_comb begin
    prop_d      = prop_q;
    integ_d     = integ_q;
    f_d         = f_q;
    dco_d       = dco_q;
    s1_valid_d  = err_valid;
    out_valid_d = s1_valid_q;
    if (clr) begin
      prop_d      = '0;
      integ_d     = '0;
      f_d         = '0;
      dco_d       = CenterDef;
      s1_valid_d  = 1'b0;
      out_valid_d = 1'b0;
    end else begin
      if (err_valid) begin
        prop_d  = e_p;
        integ_d = isat;
      end
      if (s1_valid_q) begin
        f_d   = fsat;
        dco_d = dclip;
      end
    end
  end

  // Lock detector; a lock count of 0 or 1 locks on the first qualifying sample.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (clr) begin
      state_d = StUnlocked;
      cnt_d   = '0;
    end else if (err_valid) begin
      case (state_q)
        StUnlocked: begin
          if (err_mag <= thr_q) begin
            cnt_d   = W'(1);
            state_d = (lcnt_q <= W'(1)) ? StLocked : StAcquire;
          end
        end
        StAcquire: begin
          if (err_mag <= thr_q) begin
            cnt_d = (cnt_q == '1) ? cnt_q : cnt_q + W'(1);
            if (cnt_d >= lcnt_q) state_d = StLocked;
          end else begin
            state_d = StUnlocked;
            cnt_d   = '0;
          end
        end
        StLocked: begin
          if ({1'b0, err_mag} > {thr_q, 1'b0}) begin
            state_d = StUnlocked;
            cnt_d   = '0;
          end
        end
        default: begin
          state_d = StUnlocked;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // Monitor is built from next-state values so it lines up with dco_word.
  logic [W:0]    fabs;
  logic [IW-1:0] iabs;
  logic          sat_d;

  always_comb begin
    fabs   = f_d[W] ? $unsigned(-f_d) : $unsigned(f_d);
    iabs   = integ_d[IW-1] ? $unsigned(-integ_d) : $unsigned(integ_d);
    sat_d  = (integ_d == IntegMax) || (integ_d == IntegMin);
    dout_d = '0;
    sign_d = 1'b0;
    case (out_sel)
      2'd0: begin
        dout_d = fabs[W] ? '1 : fabs[W-1:0];
        sign_d = f_d[W];
      end
      2'd1: begin
        dout_d = (|iabs[IW-1:W]) ? '1 : iabs[W-1:0];
        sign_d = integ_d[IW-1];
      end
      2'd2: dout_d = dco_d;
      default: begin
        dout_d = {{(W-2){1'b0}}, state_d};
        sign_d = sat_d;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      kp_q        <= KpDef;
      ki_q        <= KiDef;
      center_q    <= CenterDef;
      thr_q       <= ThrDef;
      lcnt_q      <= LcntDef;
      prop_q      <= '0;
      integ_q     <= '0;
      f_q         <= '0;
      dco_q       <= CenterDef;
      s1_valid_q  <= 1'b0;
      out_valid_q <= 1'b0;
      dout_q      <= '0;
      sign_q      <= 1'b0;
      state_q     <= StUnlocked;
      cnt_q       <= '0;
    end else begin
      kp_q        <= kp_d;
      ki_q        <= ki_d;
      center_q    <= center_d;
      thr_q       <= thr_d;
      lcnt_q      <= lcnt_d;
      prop_q      <= prop_d;
      integ_q     <= integ_d;
      f_q         <= f_d;
      dco_q       <= dco_d;
      s1_valid_q  <= s1_valid_d;
      out_valid_q <= out_valid_d;
      dout_q      <= dout_d;
      sign_q      <= sign_d;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
    end
  end

  assign dco_word  = dco_q;
  assign out_valid = out_valid_q;
  assign dout      = dout_q;
  assign sign      = sign_q;
  assign locked    = (state_q == StLocked);
  assign integ_sat = (integ_q == IntegMax) || (integ_q == IntegMin);

endmodule

// File: tb/tb_adpll_loop_ctrl.sv
// Bench for adpll_loop_ctrl (W=8, ACC_EXT=4): directed scenarios then random
// traffic, all checked against an integer-arithmetic model of the loop.
module tb_adpll_loop_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       clr = 1'b0;
  logic       pgm = 1'b0;
  logic [2:0] param_sel = '0;
  logic [7:0] pgm_value = '0;
  logic       err_valid = 1'b0;
  logic [7:0] err_mag = '0;
  logic       err_sign = 1'b0;
  logic [1:0] out_sel = '0;
  logic [7:0] dco_word;
  logic       out_valid;
  logic [7:0] dout;
  logic       sign_o;
  logic       locked;
  logic       integ_sat;

  int total = 0;
  int bad = 0;

  adpll_loop_ctrl #(.W(8), .ACC_EXT(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (clr),
    .pgm       (pgm),
    .param_sel (param_sel),
    .pgm_value (pgm_value),
    .err_valid (err_valid),
    .err_mag   (err_mag),
    .err_sign  (err_sign),
    .out_sel   (out_sel),
    .dco_word  (dco_word),
    .out_valid (out_valid),
    .dout      (dout),
    .sign      (sign_o),
    .locked    (locked),
    .integ_sat (integ_sat)
  );

  always #5 clk = ~clk;

  // Reference model state (plain integers).
  int m_kp, m_ki, m_center, m_thr, m_lcnt;
  int m_integ, m_prop, m_f, m_dco, m_state, m_cnt, m_dout;
  bit m_s1v, m_ov, m_sign;

  function automatic int clampi(int v, int lo, int hi);
    return (v < lo) ? lo : ((v > hi) ? hi : v);
  endfunction

  function automatic int absi(int v);
    return (v < 0) ? -v : v;
  endfunction

  function automatic bit at_rail(int v);
    return (v == 4095) || (v == -4096);
  endfunction

  task automatic mdl_reset();
    m_kp = 2; m_ki = 5; m_center = 128; m_thr = 2; m_lcnt = 16;
    m_integ = 0; m_prop = 0; m_f = 0; m_dco = 128; m_state = 0; m_cnt = 0;
    m_s1v = 0; m_ov = 0; m_dout = 0; m_sign = 0;
  endtask

  task automatic mdl_update();
    int kp_n = m_kp, ki_n = m_ki, center_n = m_center, thr_n = m_thr, lcnt_n = m_lcnt;
    int integ_n = m_integ, prop_n = m_prop, f_n = m_f, dco_n = m_dco;
    int state_n = m_state, cnt_n = m_cnt, e, mag;
    bit s1v_n, ov_n;
    mag = int'(err_mag);
    if (clr) begin
      kp_n = 2; ki_n = 5; center_n = 128; thr_n = 2; lcnt_n = 16;
      integ_n = 0; prop_n = 0; f_n = 0; dco_n = 128; state_n = 0; cnt_n = 0;
      s1v_n = 0; ov_n = 0;
    end else begin
      ov_n  = m_s1v;
      s1v_n = err_valid;
      if (m_s1v) begin
        f_n   = clampi(m_prop + m_integ, -256, 255);
        dco_n = clampi(m_center + f_n, 0, 255);
      end
      if (err_valid) begin
        e       = err_sign ? -mag : mag;
        prop_n  = e >>> m_kp;
        integ_n = clampi(m_integ + (e >>> m_ki), -4096, 4095);
        if (m_state == 0) begin
          if (mag <= m_thr) begin cnt_n = 1; state_n = (m_lcnt <= 1) ? 2 : 1; end
        end else if (m_state == 1) begin
          if (mag <= m_thr) begin
            cnt_n = (m_cnt + 1 > 255) ? 255 : m_cnt + 1;
            if (cnt_n >= m_lcnt) state_n = 2;
          end else begin
            state_n = 0; cnt_n = 0;
          end
        end else if (mag > 2 * m_thr) begin
          state_n = 0; cnt_n = 0;
        end
      end
      if (pgm) begin
        case (int'(param_sel))
          0: kp_n = int'(pgm_value) % 8;
          1: ki_n = int'(pgm_value) % 8;
          2: center_n = int'(pgm_value);
          3: thr_n = int'(pgm_value);
          4: lcnt_n = int'(pgm_value);
          default: ;
        endcase
      end
    end
    case (int'(out_sel))
      0: begin m_dout = (absi(f_n) > 255) ? 255 : absi(f_n); m_sign = (f_n < 0); end
      1: begin m_dout = (absi(integ_n) > 255) ? 255 : absi(integ_n); m_sign = (integ_n < 0); end
      2: begin m_dout = dco_n; m_sign = 0; end
      default: begin m_dout = state_n; m_sign = at_rail(integ_n); end
    endcase
    m_kp = kp_n; m_ki = ki_n; m_center = center_n; m_thr = thr_n; m_lcnt = lcnt_n;
    m_integ = integ_n; m_prop = prop_n; m_f = f_n; m_dco = dco_n;
    m_state = state_n; m_cnt = cnt_n; m_s1v = s1v_n; m_ov = ov_n;
  endtask

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("dco_word", 32'(dco_word), 32'(m_dco));
    chk("out_valid", 32'(out_valid), 32'(m_ov));
    chk("dout", 32'(dout), 32'(m_dout));
    chk("sign", 32'(sign_o), 32'(m_sign));
    chk("locked", 32'(locked), 32'(m_state == 2));
    chk("integ_sat", 32'(integ_sat), 32'(at_rail(m_integ)));
  endtask

  task automatic step();
    @(posedge clk);
    if (!rst_n) mdl_reset();
    else mdl_update();
    #1;
    check_all();
  endtask

  task automatic write_param(int sel, int val);
    pgm = 1'b1; param_sel = 3'(sel); pgm_value = 8'(val);
    step();
    pgm = 1'b0;
  endtask

  initial begin
    // Reset with the error input idle.
    #1 rst_n = 1'b0;
    #1 mdl_reset();
    check_all();
    step();
    step();
    chk("rst_dco", 32'(dco_word), 32'd128);
    chk("rst_dout", 32'(dout), 32'd0);
    chk("rst_locked", 32'(locked), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    rst_n = 1'b1;
    step();
    step();

    // Pure proportional path: kp=0, ki=7, single +8 sample.
    write_param(0, 0);
    write_param(1, 7);
    out_sel = 2'd0;
    err_valid = 1'b1; err_mag = 8'd8; err_sign = 1'b0;
    step();
    err_valid = 1'b0;
    chk("p_early_valid", 32'(out_valid), 32'd0);
    step();
    chk("p_dco", 32'(dco_word), 32'd136);
    chk("p_valid", 32'(out_valid), 32'd1);
    chk("p_dout", 32'(dout), 32'd8);
    chk("p_sign", 32'(sign_o), 32'd0);
    step();
    chk("p_valid_pulse", 32'(out_valid), 32'd0);

    // Integrator saturation at both rails.
    write_param(1, 0);
    out_sel = 2'd1;
    err_valid = 1'b1; err_mag = 8'd255; err_sign = 1'b0;
    repeat (20) step();
    chk("sat_hi_flag", 32'(integ_sat), 32'd1);
    chk("sat_hi_dco", 32'(dco_word), 32'd255);
    chk("sat_hi_dout", 32'(dout), 32'd255);
    out_sel = 2'd3;
    step();
    chk("sat_hi_status", 32'(sign_o), 32'd1);
    err_sign = 1'b1; out_sel = 2'd1;
    repeat (40) step();
    chk("sat_lo_flag", 32'(integ_sat), 32'd1);
    chk("sat_lo_dco", 32'(dco_word), 32'd0);
    chk("sat_lo_sign", 32'(sign_o), 32'd1);
    err_valid = 1'b0;
    step();

    // Lock acquisition, hold, and loss.
    write_param(3, 2);
    write_param(4, 4);
    out_sel = 2'd3;
    err_valid = 1'b1; err_mag = 8'd1;
    for (int i = 0; i < 3; i++) begin
      err_sign = 1'(i % 2);
      step();
    end
    chk("lock_before", 32'(locked), 32'd0);
    step();
    chk("lock_after4", 32'(locked), 32'd1);
    chk("lock_state", 32'(dout), 32'd2);
    err_mag = 8'd4;
    step();
    chk("lock_hold", 32'(locked), 32'd1);
    err_mag = 8'd5;
    step();
    chk("lock_lost", 32'(locked), 32'd0);
    chk("lock_lost_state", 32'(dout), 32'd0);

    // Relock, then clear with a simultaneous write that must be dropped.
    err_mag = 8'd1; err_sign = 1'b0;
    repeat (4) step();
    chk("relock", 32'(locked), 32'd1);
    err_valid = 1'b0;
    clr = 1'b1; pgm = 1'b1; param_sel = 3'd0; pgm_value = 8'd7;
    step();
    clr = 1'b0; pgm = 1'b0;
    chk("clr_locked", 32'(locked), 32'd0);
    out_sel = 2'd1;
    step();
    chk("clr_integ", 32'(dout), 32'd0);
    chk("clr_integ_sign", 32'(sign_o), 32'd0);
    out_sel = 2'd2;
    err_valid = 1'b1; err_mag = 8'd64; err_sign = 1'b0;
    step();
    err_valid = 1'b0;
    step();
    chk("clr_defaults_dco", 32'(dco_word), 32'd146);

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      clr = ($urandom_range(0, 39) == 0);
      pgm = ($urandom_range(0, 7) == 0);
      param_sel = 3'($urandom_range(0, 7));
      pgm_value = (param_sel >= 3'd3) ? 8'($urandom_range(0, 7)) : 8'($urandom_range(0, 255));
      err_valid = ($urandom_range(0, 9) < 7);
      err_mag = ($urandom_range(0, 1) == 1) ? 8'($urandom_range(0, 5)) : 8'($urandom_range(0, 255));
      err_sign = 1'($urandom_range(0, 1));
      out_sel = 2'($urandom_range(0, 3));
      step();
    end
    clr = 1'b0; pgm = 1'b0;

    // Asynchronous reset between edges, then a sample in the release cycle.
    err_valid = 1'b1; err_mag = 8'd3; err_sign = 1'b0; out_sel = 2'd2;
    repeat (3) step();
    #2 rst_n = 1'b0;
    #1 mdl_reset();
    check_all();
    chk("arst_dco", 32'(dco_word), 32'd128);
    chk("arst_dout", 32'(dout), 32'd0);
    chk("arst_out_valid", 32'(out_valid), 32'd0);
    err_mag = 8'd10;
    step();
    #2 rst_n = 1'b1;
    step();
    err_valid = 1'b0;
    step();
    chk("release_sample_dco", 32'(dco_word), 32'd130);
    chk("release_sample_valid", 32'(out_valid), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/adpll_loop_ctrl.md
ADPLL_LOOP_CTRL -- requirements
Module: adpll_loop_ctrl

Interface
REQ-001 SHALL have parameter W, default 8, meaning error/DCO word width (legal 5..16).
REQ-002 SHALL have parameter ACC_EXT, default 4, meaning extra integrator guard bits; integrator width IW = W+1+ACC_EXT signed.
REQ-003 SHALL have port clk  input  1  meaning the single sample clock; every register changes on its rising edge, except on reset.
REQ-004 SHALL have port rst_n  input  1  meaning asynchronous active-low reset.
REQ-005 SHALL have port clr  input  1  meaning synchronous clear of parameters, integrator and lock state.
REQ-006 SHALL have port pgm  input  1  meaning write strobe for the parameter selected by param_sel.
REQ-007 SHALL have port param_sel  input  3  meaning parameter index: 0 kp_shift, 1 ki_shift, 2 center, 3 lock_thr, 4 lock_cnt; 5..7 reserved.
REQ-008 SHALL have port pgm_value  input  W  meaning the parameter write data.
REQ-009 SHALL have port err_valid  input  1  meaning err_mag and err_sign carry a new phase-error sample this cycle.
REQ-010 SHALL have port err_mag  input  W  meaning unsigned phase-error magnitude.
REQ-011 SHALL have port err_sign  input  1  meaning error sign (1 = negative).
REQ-012 SHALL have port out_sel  input  2  meaning monitor select: 0 filter, 1 integrator, 2 DCO word, 3 status.
REQ-013 SHALL have port dco_word  output  W  meaning the registered DCO control word.
REQ-014 SHALL have port out_valid  output  1  meaning a one-cycle pulse when dco_word updates.
REQ-015 SHALL have port dout  output  W  meaning the monitor magnitude.
REQ-016 SHALL have port sign  output  1  meaning the monitor sign or flag.
REQ-017 SHALL have port locked  output  1  meaning the lock FSM is in LOCKED.
REQ-018 SHALL have port integ_sat  output  1  meaning the integrator is currently clamped at a rail.

Function
REQ-019 Parameter write: pgm=1 and clr=0 in a cycle SHALL load pgm_value into the selected register, truncated to its field width: kp/ki 3 bits, center W, lock_thr W, lock_cnt W. Writes to sel 5..7 SHALL be ignored.
REQ-020 clr=1 SHALL restore all parameters to defaults and zero the integrator, lock counter and pipeline. clr SHALL take priority over a simultaneous pgm or err_valid.
REQ-021 Parameter defaults SHALL be: kp_shift=2, ki_shift=5, center=2^(W-1), lock_thr=2, lock_cnt=16.
REQ-022 Signed error e SHALL be W+1 bits: +err_mag when err_sign=0, -err_mag when err_sign=1.
REQ-023 Stage 1, on the cycle with err_valid=1: prop <= e >>> kp_shift (arithmetic); integ <= sat_IW(integ + (e >>> ki_shift)).
REQ-024 Integrator saturation SHALL clamp to [-2^(IW-1), 2^(IW-1)-1] with no wrap; integ_sat=1 exactly while integ equals a rail.
REQ-025 Stage 2, one cycle after stage 1: f = sat to W+1 signed of (prop + integ); dco_word <= clip(center + f) to [0, 2^W-1]; out_valid pulses.
REQ-026 Latency: err_valid at cycle n SHALL give dco_word and out_valid at n+2. Back-to-back err_valid every cycle SHALL be supported at full throughput.
REQ-027 A parameter written at cycle n SHALL apply to samples with err_valid at n+1 or later.
REQ-028 Monitor mux, registered with dco_word:
- out_sel 0: dout = min(|f|, 2^W-1), sign = f<0.
- out_sel 1: dout = min(|integ|, 2^W-1), sign = integ<0.
- out_sel 2: dout = dco_word, sign = 0.
- out_sel 3: dout = {0, state[1:0]}, sign = integ_sat.
REQ-029 Lock FSM states and encodings: UNLOCKED=0, ACQUIRE=1, LOCKED=2. It SHALL evaluate only on err_valid.
- UNLOCKED: err_mag<=lock_thr -> ACQUIRE, cnt=1.
- ACQUIRE: err_mag<=lock_thr -> cnt+1; cnt reaching lock_cnt -> LOCKED. err_mag>lock_thr -> UNLOCKED, cnt=0.
- LOCKED: err_mag > 2*lock_thr (computed at W+1 bits) -> UNLOCKED, cnt=0; otherwise stay.
REQ-030 lock_cnt=0 or 1 SHALL give LOCKED on the first qualifying sample. cnt SHALL saturate and never wrap.
REQ-031 locked SHALL be registered: it asserts the cycle after the qualifying sample.

Reset
REQ-032 rst_n=0 SHALL asynchronously force:
- parameters to defaults;
- integ=0, prop=0, state=UNLOCKED, cnt=0;
- dco_word=2^(W-1), dout=0, sign=0, out_valid=0, locked=0, integ_sat=0.
REQ-033 Reset deassertion SHALL be honoured at the next clk edge. An err_valid sample present in that same cycle SHALL be processed normally.

Verification (W=8, ACC_EXT=4)
REQ-034 Reset with err_valid idle -> dco_word=128, dout=0, locked=0, out_valid=0.
REQ-035 Program kp=0 (sel0) and ki=7 (sel1), then a single err +8 -> two cycles later dco_word=136, out_valid=1 for one cycle; out_sel=0 gives dout=8, sign=0.
REQ-036 Program ki=0, then err_mag=255 with err_sign=0 on every cycle -> integ clamps at 4095, integ_sat=1, dco_word=255. Repeat with err_sign=1 -> integ reaches -4096, dco_word=0.
REQ-037 Program lock_thr=2 and lock_cnt=4, then four samples of err_mag=1 -> locked=1 the cycle after the 4th. Then err_mag=4 -> stays locked. Then err_mag=5 -> locked=0, state=0.
REQ-038 While locked with integ nonzero, assert clr together with pgm=1 -> parameters are defaults, integ=0, locked=0, and the pgm write is discarded.
REQ-039 Assert rst_n=0 between clock edges mid-stream -> all outputs take reset values immediately, without waiting for a clk edge.
